udp_rx_demux: RTL

UDP_RX_DEMUX -- requirements
Module: udp_rx_demux

---
 rtl/udp_rx_demux_if.sv | 47 ++++
 rtl/udp_rx_demux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/udp_rx_demux_if.sv
// udp_rx_demux_if -- bundle between the IP/MAC layer and the UDP receive demultiplexer.
//
// Producer side (master) drives:
//   rx_enable, data           UDP segment byte stream, one byte per cycle while rx_enable is high
//   to_ip, broadcast,         addressing of the frame, stable while rx_enable is high
//   remote_mac, remote_ip,
//   local_ip
// Demultiplexer side (slave) drives:
//   active, port_idx          payload byte for an accepted port, and which one
//   dhcp_active               payload byte for the DHCP client port
//   pkt_start, pkt_trunc      acceptance / truncation pulses
//   to_port, payload_len,     registered header fields of the segment
//   udp_destination_ip/mac/port
interface udp_rx_demux_if #(
    parameter int unsigned LEN_W = 11
);
    logic             rx_enable;
    logic [7:0]       data;
    logic [31:0]      to_ip;
    logic             broadcast;
    logic [47:0]      remote_mac;
    logic [31:0]      remote_ip;
    logic [31:0]      local_ip;

    logic             active;
    logic [2:0]       port_idx;
    logic             dhcp_active;
    logic             pkt_start;
    logic             pkt_trunc;
    logic [15:0]      to_port;
    logic [LEN_W-1:0] payload_len;
    logic [31:0]      udp_destination_ip;
    logic [47:0]      udp_destination_mac;
    logic [15:0]      udp_destination_port;

    modport master (
        output rx_enable, data, to_ip, broadcast, remote_mac, remote_ip, local_ip,
        input  active, port_idx, dhcp_active, pkt_start, pkt_trunc, to_port, payload_len,
               udp_destination_ip, udp_destination_mac, udp_destination_port
    );

    modport slave (
        input  rx_enable, data, to_ip, broadcast, remote_mac, remote_ip, local_ip,
        output active, port_idx, dhcp_active, pkt_start, pkt_trunc, to_port, payload_len,
               udp_destination_ip, udp_destination_mac, udp_destination_port
    );
endinterface

// File: rtl/udp_rx_demux.sv
// udp_rx_demux -- parses the 8-byte UDP header of an incoming segment and flags the payload
// bytes of segments addressed to one of NUM_PORTS consecutive ports starting at BASE_PORT.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      synchronous, active-high
//   bus        udp_rx_demux_if.slave (byte stream + addressing in, flags + header fields out)
//
// Optional feature: define UDP_RX_DHCP_EN to also accept port 68 (DHCP client) regardless of
// broadcast/to_ip; its payload raises dhcp_active instead of active. Without the macro port 68
// is rejected and dhcp_active is tied low.
module udp_rx_demux #(
    parameter int unsigned NUM_PORTS = 4,
    parameter logic [15:0] BASE_PORT = 16'd1024,
    parameter int unsigned LEN_W     = 11
) (
    input logic           clock,
    input logic           reset,
    udp_rx_demux_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StPort, StVerify, StPayload, StDone} state_e;

    localparam logic [16:0] TopPort = 17'(BASE_PORT) + 17'(NUM_PORTS) - 17'd1;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] byte_no_q, byte_no_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      src_port_q, src_port_d;
    logic [15:0]      to_port_q, to_port_d;
    logic             dhcp_q, dhcp_d;
    logic             trunc_q, trunc_d;
    logic [LEN_W-1:0] payload_len_q, payload_len_d;
    logic [31:0]      dst_ip_q, dst_ip_d;
    logic [47:0]      dst_mac_q, dst_mac_d;
    logic [15:0]      dst_port_q, dst_port_d;

    logic in_range, is_dhcp, addr_ok, accept, pkt_start, in_payload;

    // Acceptance terms; only meaningful once header bytes 3..6 have been captured.
    always_comb begin
        in_range = (to_port_q >= BASE_PORT) && ({1'b0, to_port_q} <= TopPort);
`ifdef UDP_RX_DHCP_EN
        is_dhcp  = (to_port_q == 16'd68);
`else
        is_dhcp  = 1'b0;
`endif
        addr_ok  = bus.broadcast ? (to_port_q == BASE_PORT) : (bus.to_ip == bus.local_ip);
        accept   = (is_dhcp || (in_range && addr_ok)) && (len_q >= LEN_W'(9));
    end

    always_comb begin
        state_d       = state_q;
        byte_no_d     = byte_no_q + LEN_W'(1);
        len_d         = len_q;
        src_port_d    = src_port_q;
        to_port_d     = to_port_q;
        dhcp_d        = dhcp_q;
        trunc_d       = 1'b0;
        payload_len_d = payload_len_q;
        dst_ip_d      = dst_ip_q;
        dst_mac_d     = dst_mac_q;
        dst_port_d    = dst_port_q;
        pkt_start     = 1'b0;

        if (!bus.rx_enable) begin
            state_d   = StIdle;
            byte_no_d = '0;
            // Still in PAYLOAD means the byte where byte_no == length never arrived.
            trunc_d   = (state_q == StPayload);
        end else begin
            unique case (state_q)
                StIdle: begin
                    src_port_d[15:8] = bus.data;
                    byte_no_d        = LEN_W'(2);
                    state_d          = StPort;
                end
                StPort: begin
                    src_port_d[7:0] = bus.data;
                    byte_no_d       = LEN_W'(3);
                    state_d         = StVerify;
                end
                StVerify: begin
                    if (byte_no_q == LEN_W'(3)) begin
                        to_port_d[15:8] = bus.data;
                    end else if (byte_no_q == LEN_W'(4)) begin
                        to_port_d[7:0] = bus.data;
                    end else if (byte_no_q == LEN_W'(5)) begin
                        // Keep only the low LEN_W bits of the 16-bit length.
                        len_d = LEN_W'({bus.data, 8'h00});
                    end else if (byte_no_q == LEN_W'(6)) begin
                        len_d = len_q | LEN_W'(bus.data);
                    end else if (byte_no_q == LEN_W'(8)) begin
                        if (accept) begin
                            payload_len_d = len_q;
                            dst_ip_d      = bus.remote_ip;
                            dst_mac_d     = bus.remote_mac;
                            dst_port_d    = src_port_q;
                            dhcp_d        = is_dhcp;
                            pkt_start     = 1'b1;
                            state_d       = StPayload;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StPayload: begin
                    if (byte_no_q == len_q) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            byte_no_q     <= '0;
            len_q         <= '0;
            src_port_q    <= '0;
            to_port_q     <= '0;
            dhcp_q        <= 1'b0;
            trunc_q       <= 1'b0;
            payload_len_q <= '0;
            dst_ip_q      <= '0;
            dst_mac_q     <= '0;
            dst_port_q    <= '0;
        end else begin
            state_q       <= state_d;
            byte_no_q     <= byte_no_d;
            len_q         <= len_d;
            src_port_q    <= src_port_d;
            to_port_q     <= to_port_d;
            dhcp_q        <= dhcp_d;
            trunc_q       <= trunc_d;
            payload_len_q <= payload_len_d;
            dst_ip_q      <= dst_ip_d;
            dst_mac_q     <= dst_mac_d;
            dst_port_q    <= dst_port_d;
        end
    end

    // Zero-latency payload flag: the current byte is payload if we are in PAYLOAD and it is valid.
    assign in_payload = (state_q == StPayload) && bus.rx_enable;

    assign bus.active      = in_payload && !dhcp_q;
`ifdef UDP_RX_DHCP_EN
    assign bus.dhcp_active = in_payload && dhcp_q;
`else
    assign bus.dhcp_active = 1'b0;
`endif
    assign bus.port_idx             = 3'(to_port_q - BASE_PORT);
    assign bus.pkt_start            = pkt_start;
    assign bus.pkt_trunc            = trunc_q;
    assign bus.to_port              = to_port_q;
    assign bus.payload_len          = payload_len_q;
    assign bus.udp_destination_ip   = dst_ip_q;
    assign bus.udp_destination_mac  = dst_mac_q;
    assign bus.udp_destination_port = dst_port_q;

endmodule
